// File: rtl/ltu_pkg.sv
// Shared types and constants for the line transfer unit: FSM encoding, line
// geometry, status bit positions and the beat address helper.
package ltu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_READ       = 2'd2,
        ST_READ_DRAIN = 2'd3
    } ltu_state_e;

    localparam int LINE_BEATS = 32;
    localparam int BEAT_BYTES = 8;
    localparam int LINE_SHIFT = 8;
    localparam int BEAT_W     = 64;
    localparam int LINE_W     = LINE_BEATS * BEAT_W;
    localparam int LINE_IDX_W = 14;
    localparam int BEAT_IDX_W = 5;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_PEND    = 1;
    localparam int STAT_DROP    = 2;
    localparam int STAT_CNT_LSB = 16;

    // 32-bit byte address of one beat; the sum wraps modulo 2^32.
    function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                              input logic [LINE_IDX_W-1:0] line,
                                              input logic [BEAT_IDX_W-1:0] beat);
        return base + ({18'd0, line} << LINE_SHIFT) + ({27'd0, beat} << 3);
    endfunction

endpackage

// File: rtl/ltu_line_buffer.sv
// 32 x 64-bit line storage: beat-indexed write and read ports, full-line
// parallel load for flush snapshots and full-line view for refill commit.
module ltu_line_buffer
    import ltu_pkg::*;
(
    input  logic                  i_SYSTEM_clk,
    input  logic                  i_SYSTEM_rst,
    input  logic                  load,
    input  logic [LINE_W-1:0]     load_line,
    input  logic                  wr_en,
    input  logic [BEAT_IDX_W-1:0] wr_idx,
    input  logic [BEAT_W-1:0]     wr_data,
    input  logic [BEAT_IDX_W-1:0] rd_idx,
    output logic [BEAT_W-1:0]     rd_data,
    output logic [LINE_W-1:0]     line
);

    logic [BEAT_W-1:0] mem [LINE_BEATS];

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            for (int i = 0; i < LINE_BEATS; i++) mem[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < LINE_BEATS; i++) mem[i] <= load_line[i*BEAT_W +: BEAT_W];
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_BEATS; i++) line[i*BEAT_W +: BEAT_W] = mem[i];
    end

endmodule

// File: rtl/line_transfer_unit.sv
// Moves whole 2048-bit point lines between the ExMU and a 64-bit beat memory
// port: flushes (WRITE) and refills (READ, READ_DRAIN) through one line buffer.
module line_transfer_unit
    import ltu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 8
) (
    input  logic              i_SYSTEM_clk,
    input  logic              i_SYSTEM_rst,
    input  logic              i_CU_LTU_readReq,
    input  logic [18:0]       i_ExMU_readID,
    input  logic              i_CU_LTU_writeReq,
    input  logic [18:0]       i_ExMU_writeID,
    input  logic [LINE_W-1:0] i_ExMU_writePayload,
    output logic [LINE_W-1:0] o_INT_readPayload,
    output logic              o_LTU_readDone,
    output logic              o_LTU_writeDone,
    output logic              o_LTU_busy,
    output logic              o_MEM_valid,
    input  logic              i_MEM_ready,
    output logic              o_MEM_we,
    output logic [31:0]       o_MEM_addr,
    output logic [63:0]       o_MEM_wdata,
    input  logic              i_MEM_rvalid,
    input  logic [63:0]       i_MEM_rdata,
    output logic [31:0]       o_status,
    output logic [1:0]        o_dbg_state
);

    localparam logic [5:0] MAX_OUT = 6'(MAX_OUTSTANDING);

    ltu_state_e            state;
    logic [5:0]            issue_cnt;
    logic [5:0]            resp_cnt;
    logic [5:0]            outstanding;
    logic [LINE_IDX_W-1:0] wr_line;
    logic [LINE_IDX_W-1:0] rd_line;
    logic                  rd_pending;
    logic                  dropped;
    logic [15:0]           xfer_cnt;

    logic [BEAT_W-1:0]     buf_rd_data;
    logic [LINE_W-1:0]     buf_line;
    logic [LINE_W-1:0]     commit_line;
    logic                  in_write, in_read, mem_valid, beat_accept;
    logic                  resp_take, last_resp, buf_load;
    logic [LINE_IDX_W-1:0] cur_line;
    logic                  id_low_unused;

    assign id_low_unused = ^{i_ExMU_readID[4:0], i_ExMU_writeID[4:0]};

    // Request channel: a beat transfers on a cycle with o_MEM_valid & i_MEM_ready;
    // addr/we/wdata derive only from registered state, so they hold while stalled.
    assign in_write    = (state == ST_WRITE);
    assign in_read     = (state == ST_READ);
    assign mem_valid   = (in_write && !issue_cnt[5]) ||
                         (in_read && !issue_cnt[5] && (outstanding < MAX_OUT));
    assign beat_accept = mem_valid && i_MEM_ready;
    assign resp_take   = i_MEM_rvalid && (outstanding != 6'd0);
    assign last_resp   = resp_take && (resp_cnt == 6'(LINE_BEATS - 1));
    assign buf_load    = (state == ST_IDLE) && i_CU_LTU_writeReq;
    assign cur_line    = in_write ? wr_line : rd_line;

    // The final response is merged here so the commit lands one cycle after it.
    always_comb begin
        commit_line = buf_line;
        commit_line[(LINE_BEATS-1)*BEAT_W +: BEAT_W] = i_MEM_rdata;
    end

    ltu_line_buffer u_line_buffer (
        .i_SYSTEM_clk (i_SYSTEM_clk),
        .i_SYSTEM_rst (i_SYSTEM_rst),
        .load         (buf_load),
        .load_line    (i_ExMU_writePayload),
        .wr_en        (resp_take),
        .wr_idx       (resp_cnt[4:0]),
        .wr_data      (i_MEM_rdata),
        .rd_idx       (issue_cnt[4:0]),
        .rd_data      (buf_rd_data),
        .line         (buf_line)
    );

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            state             <= ST_IDLE;
            issue_cnt         <= '0;
            resp_cnt          <= '0;
            outstanding       <= '0;
            wr_line           <= '0;
            rd_line           <= '0;
            rd_pending        <= 1'b0;
            dropped           <= 1'b0;
            xfer_cnt          <= '0;
            o_LTU_readDone    <= 1'b0;
            o_LTU_writeDone   <= 1'b0;
            o_INT_readPayload <= '0;
        end else begin
            o_LTU_readDone  <= 1'b0;
            o_LTU_writeDone <= 1'b0;

            if (beat_accept && in_read && !resp_take)
                outstanding <= outstanding + 6'd1;
            else if (resp_take && !(beat_accept && in_read))
                outstanding <= outstanding - 6'd1;

            if (resp_take) resp_cnt <= resp_cnt + 6'd1;
            if (last_resp) begin
                o_INT_readPayload <= commit_line;
                o_LTU_readDone    <= 1'b1;
                xfer_cnt          <= xfer_cnt + 16'd1;
            end

            if ((state != ST_IDLE) && (i_CU_LTU_readReq || i_CU_LTU_writeReq))
                dropped <= 1'b1;

            case (state)
                ST_IDLE: begin
                    issue_cnt <= '0;
                    resp_cnt  <= '0;
                    if (i_CU_LTU_writeReq) begin
                        wr_line <= i_ExMU_writeID[18:5];
                        state   <= ST_WRITE;
                        if (i_CU_LTU_readReq) begin
                            rd_line    <= i_ExMU_readID[18:5];
                            rd_pending <= 1'b1;
                        end
                    end else if (i_CU_LTU_readReq) begin
                        rd_line <= i_ExMU_readID[18:5];
                        state   <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (beat_accept) begin
                        issue_cnt <= issue_cnt + 6'd1;
                        if (issue_cnt == 6'(LINE_BEATS - 1)) begin
                            o_LTU_writeDone <= 1'b1;
                            xfer_cnt        <= xfer_cnt + 16'd1;
                        end
                    end
                    // Held here for the done cycle so busy covers it.
                    if (issue_cnt[5]) begin
                        issue_cnt <= '0;
                        resp_cnt  <= '0;
                        if (rd_pending) begin
                            rd_pending <= 1'b0;
                            state      <= ST_READ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (beat_accept) begin
                        issue_cnt <= issue_cnt + 6'd1;
                        if (issue_cnt == 6'(LINE_BEATS - 1)) state <= ST_READ_DRAIN;
                    end
                end
                ST_READ_DRAIN: begin
                    if (resp_cnt[5]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_MEM_valid = mem_valid;
    assign o_MEM_we    = mem_valid && in_write;
    assign o_MEM_addr  = mem_valid ? beat_addr(BASE_ADDR, cur_line, issue_cnt[4:0]) : 32'd0;
    assign o_MEM_wdata = (mem_valid && in_write) ? buf_rd_data : 64'd0;
    assign o_LTU_busy  = (state != ST_IDLE);
    assign o_dbg_state = state;

    always_comb begin
        o_status                               = '0;
        o_status[STAT_BUSY]                    = o_LTU_busy;
        o_status[STAT_PEND]                    = rd_pending;
        o_status[STAT_DROP]                    = dropped;
        o_status[STAT_CNT_LSB +: 16]           = xfer_cnt;
    end

endmodule
